// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared constants for the bit-serial subtractor
package serial_subtractor_pkg;

  // Default operand/result width
  localparam int DEFAULT_WIDTH = 8;

  // FSM state encodings, kept as plain constants for legacy tools
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand and result bundle
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  // Requester side: issues operands, observes status and result
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  // Subtractor side
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );

endinterface

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - 1-bit combinational full subtractor cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  logic hs1_diff;
  logic hs1_borrow;
  logic hs2_borrow;

  // First half-subtractor stage: a - b
  assign hs1_diff   = a ^ b;
  assign hs1_borrow = ~a & b;

  // Second half-subtractor stage: (a - b) - b_in
  assign diff       = hs1_diff ^ b_in;
  assign hs2_borrow = ~hs1_diff & b_in;

  // A borrow from either stage propagates out
  assign b_out = hs1_borrow | hs2_borrow;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)(
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q,      state_d;
  logic [WIDTH-1:0] a_sr_q,       a_sr_d;
  logic [WIDTH-1:0] b_sr_q,       b_sr_d;
  logic [WIDTH-1:0] diff_sr_q,    diff_sr_d;
  logic             borrow_q,     borrow_d;
  logic [CW-1:0]    cnt_q,        cnt_d;
  logic [WIDTH-1:0] diff_q,       diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q,   overflow_d;

  logic cell_diff;
  logic cell_borrow;

  full_subtractor u_cell (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .b_in  (borrow_q),
    .diff  (cell_diff),
    .b_out (cell_borrow)
  );

  // Next-state logic: capture on start, one bit per cycle in RUN, publish on the last bit
  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    diff_sr_d    = diff_sr_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sr_d   = bus.a;
          b_sr_d   = bus.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        diff_sr_d = {cell_diff, diff_sr_q[WIDTH-1:1]};
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        borrow_d  = cell_borrow;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // borrow_q is the borrow into the MSB cell on this cycle
          diff_d       = diff_sr_d;
          borrow_out_d = cell_borrow;
          overflow_d   = borrow_q ^ cell_borrow;
          cnt_d        = '0;
          state_d      = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      diff_sr_q    <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      diff_sr_q    <= diff_sr_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.busy       = (state_q == ST_RUN);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   done_cyc = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ov, borrow, diff} from plain (W+1)-bit unsigned subtraction and the signed overflow rule
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] full;
    logic       ov;
    full = {1'b0, a} - {1'b0, b};
    ov   = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    return {ov, full};
  endfunction

  // Issue one operation; checks latency, busy count, output hold during RUN, busy/done exclusivity
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int glitch_at,
                        input string tag);
    logic [W-1:0] prev_diff;
    logic         prev_bo;
    logic         prev_ov;
    int           busy_cnt;
    bit           seen;
    bit           hold_ok;
    bit           overlap;
    @(posedge clk); #1;
    prev_diff = bus.diff;
    prev_bo   = bus.borrow_out;
    prev_ov   = bus.overflow;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    busy_cnt  = 0;
    seen      = 1'b0;
    hold_ok   = 1'b1;
    overlap   = 1'b0;
    for (int i = 0; i < 3 * W && !seen; i++) begin
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.diff !== prev_diff || bus.borrow_out !== prev_bo || bus.overflow !== prev_ov)
          hold_ok = 1'b0;
        if (glitch_at > 0 && busy_cnt == glitch_at) begin
          bus.start = 1'b1;
          bus.a     = 8'hAA;
          bus.b     = 8'h55;
        end else begin
          bus.start = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    if (seen) done_cyc = cyc;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({tag, "_hold_in_run"}, 32'(hold_ok), 32'd1);
    check({tag, "_busy_and_done"}, 32'(overlap), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] d, input logic bo, input logic ov);
    check({tag, "_diff"}, 32'(bus.diff), 32'(d));
    check({tag, "_borrow_out"}, 32'(bus.borrow_out), 32'(bo));
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(ov));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W+1:0] exp_v;
    int           prev_done;
    int           extra_done;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check_result("reset", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 0, "basic");
    check_result("basic", 8'h02, 1'b0, 1'b0);

    run_op(8'h03, 8'h05, 0, "ubor");
    check_result("ubor", 8'hFE, 1'b1, 1'b0);

    run_op(8'h80, 8'h01, 0, "sovf1");
    check_result("sovf1", 8'h7F, 1'b0, 1'b1);

    // Results must persist in IDLE after the done pulse
    repeat (3) @(posedge clk);
    #1;
    check_result("hold_idle", 8'h7F, 1'b0, 1'b1);

    run_op(8'h10, 8'h01, 3, "ignore");
    check_result("ignore", 8'h0F, 1'b0, 1'b0);
    extra_done = 0;
    for (int i = 0; i < 2 * W + 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) extra_done++;
    end
    check("ignore_no_second_done", 32'(extra_done), 32'd0);

    run_op(8'h7F, 8'hFF, 0, "sovf2");
    check_result("sovf2", 8'h80, 1'b1, 1'b1);

    // Reset in RUN cycle 4: outputs must clear without waiting for a clock edge
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h33;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check_result("midrst", 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("postrst_idle_busy", 32'(bus.busy), 32'd0);
    check("postrst_idle_done", 32'(bus.done), 32'd0);
    run_op(8'h00, 8'h00, 0, "zero");
    check_result("zero", 8'h00, 1'b0, 1'b0);

    // Back-to-back random operations: start lands in the IDLE cycle right after each done
    prev_done = done_cyc;
    for (int n = 0; n < 1000; n++) begin
      ra    = W'($urandom);
      rb    = W'($urandom);
      exp_v = ref_sub(ra, rb);
      run_op(ra, rb, 0, "rand");
      check_result("rand", exp_v[W-1:0], exp_v[W], exp_v[W+1]);
      check("rand_done_spacing", 32'(done_cyc - prev_done), 32'(W + 2));
      prev_done = done_cyc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
